qam_mapper: RTL and testbench
=============================

Name: qam_mapper

Overview:
Hard-decision 16QAM mapper (modulator). It is the transmit-side counterpart of the QAM demapper.
- Accepts a serial bit stream through a valid/ready handshake.
- Packs 4 bits per symbol, MSB first.
- Gray-maps each symbol to signed I/Q amplitudes on the same 8-bit signed format the demapper consumes.
- Presents symbols on a 1-deep valid/ready output register so a DAC/channel model can apply back-pressure.

Parameters:
- WIDTH, 8: I/Q output width, signed two's complement.
- AMP, 32: unit amplitude; levels are ±AMP and ±3*AMP. Legal only if 3*AMP <= 2^(WIDTH-1)-1.
- PRE_LEN, 8: preamble length in symbols (used only with the optional feature).

Ports:
- dclk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: mapper enable. Low = discard partial symbol, accept no bits.
- bit_in, input, 1: serial data bit.
- bit_valid, input, 1: bit_in is valid this cycle.
- bit_ready, output, 1: mapper accepts bit this cycle.
- I_out, output, WIDTH: in-phase amplitude, signed.
- Q_out, output, WIDTH: quadrature amplitude, signed.
- sym_valid, output, 1: I_out/Q_out hold an unconsumed symbol.
- sym_ready, input, 1: downstream consumes symbol this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - sr=0, cnt=0, sym_valid=0, I_out=0, Q_out=0, bit_ready=0.
  - State=PRE if SYM_PREAMBLE_EN is defined, else RUN.
- Bit accept: a bit is accepted on a rising edge when bit_valid & bit_ready. The first accepted bit of a symbol is b3, the last is b0.
- cnt counts accepted bits 0..3 and wraps 3->0 on the 4th accepted bit.
- bit_ready = en & (state==RUN) & !(cnt==3 & sym_valid & !sym_ready). The 4th bit is refused only while the output register is full and not draining.
- Symbol launch: on the edge that accepts the 4th bit, {b3,b2} maps to I_out and {b1,b0} maps to Q_out; sym_valid is set to 1.
- Latency: sym_valid is high in the cycle after the 4th-bit edge.
- Gray map, per axis: 00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP. With defaults: -96, -32, +32, +96.
- Compute in WIDTH+2 bits, then truncate; no saturation is needed given the AMP constraint.
- Output handshake:
  - sym_valid clears on an edge with sym_ready=1 unless a new symbol launches on the same edge. Simultaneous drain and launch keeps sym_valid=1 with the new I/Q.
  - I_out/Q_out are held stable while sym_valid=1 and sym_ready=0.
  - After a drain, I_out/Q_out keep their last value; only sym_valid qualifies them.
- en low: cnt and sr are cleared on the next edge, discarding the partial symbol. The output register and its handshake continue unaffected; a pending symbol still drains.
- Reset mid-operation clears everything; a pending symbol is lost.
- States: PRE (preamble, feature only) -> RUN. RUN is terminal until reset.

Optional Feature:
Macro SYM_PREAMBLE_EN.
- Defined: after reset release, state=PRE and bit_ready=0.
  - The mapper emits PRE_LEN symbols through the normal output handshake.
  - Symbols alternate (+3*AMP,+3*AMP) and (-3*AMP,-3*AMP), starting positive.
  - A preamble counter advances on each drained symbol.
  - After the last preamble symbol drains, state moves to RUN.
  - en is ignored in PRE.
  - This gives the demapper a known corner pattern for its cal/offset latch.
- Undefined: no PRE state or preamble counter; the block starts in RUN immediately after reset.

Test Plan:
1. Reset then en=1, bits 1,0,1,1 continuous, sym_ready=1 -> sym_valid one cycle after 4th bit, I_out=+96, Q_out=+32, then sym_valid=0 next cycle.
2. All 16 nibbles streamed back-to-back (0000..1111) with sym_ready=1 -> 16 symbols, one per 4 bits, each matching the Gray table (e.g. 0000 -> (-96,-96), 0110 -> (-32,+96)), bit_ready never drops.
3. sym_ready=0 held, stream 8 bits -> first symbol held stable, bit_ready=0 while cnt==3, 4th bit of second symbol stalled; raise sym_ready -> second symbol appears next cycle with no bit lost.
4. Bits 1,1 then en=0 for 1 cycle, then 0,0,0,1 -> partial discarded, symbol = (-96,-32).
5. Assert rst low mid-symbol with sym_valid=1 -> sym_valid, I_out, Q_out go to 0 immediately (asynchronous), no symbol after release until 4 new bits.
6. With SYM_PREAMBLE_EN, PRE_LEN=8, sym_ready=1 -> 8 symbols alternating (+96,+96)/(-96,-96), bit_ready=0 throughout, bit_ready=1 the cycle after the 8th drains.

Source files
------------

// File: rtl/qam_mapper.sv
// Hard-decision 16QAM Gray mapper: serial bits in, 4 bits per symbol, signed I/Q out
// through a 1-deep valid/ready register. Define SYM_PREAMBLE_EN to emit a corner preamble first.
module qam_mapper #(
    parameter int WIDTH   = 8,
    parameter int AMP     = 32,
    parameter int PRE_LEN = 8
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] I_out,
    output logic [WIDTH-1:0] Q_out,
    output logic             sym_valid,
    input  logic             sym_ready
);

    // Levels are computed two bits wider than the output, then truncated.
    localparam logic signed [WIDTH+1:0] LVL1 = (WIDTH + 2)'(AMP);
    localparam logic signed [WIDTH+1:0] LVL3 = (WIDTH + 2)'(3 * AMP);

    if ((3 * AMP > 2 ** (WIDTH - 1) - 1) || (PRE_LEN < 1)) begin : g_bad_cfg
        $error("qam_mapper: AMP too large for WIDTH, or PRE_LEN < 1");
    end

    function automatic logic [WIDTH-1:0] gray_level(input logic [1:0] b);
        logic signed [WIDTH+1:0] v;
        case (b)
            2'b00:   v = -LVL3;
            2'b01:   v = -LVL1;
            2'b11:   v = LVL1;
            default: v = LVL3;
        endcase
        return v[WIDTH-1:0];
    endfunction

    logic [2:0]       sr_q, sr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sym_valid_q, sym_valid_d;
    logic             in_run;
    logic             drain;
    logic             bit_acc;

`ifdef SYM_PREAMBLE_EN
    localparam int PCW = $clog2(PRE_LEN + 1);

    typedef enum logic {
        ST_PRE,
        ST_RUN
    } state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
    logic [PCW:0]   pre_launched;

    assign in_run       = (state_q == ST_RUN);
    // Symbols launched so far = drained ones plus the one still sitting in the output register.
    assign pre_launched = {1'b0, pre_cnt_q} + (PCW + 1)'(sym_valid_q);
`else
    assign in_run = 1'b1;
`endif

    // The 4th bit is refused only while the output register is full and not draining.
    assign bit_ready = rst & en & in_run & ~((cnt_q == 2'd3) & sym_valid_q & ~sym_ready);
    assign bit_acc   = bit_valid & bit_ready;
    assign drain     = sym_valid_q & sym_ready;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        i_d         = i_q;
        q_d         = q_q;
        sym_valid_d = sym_valid_q;
`ifdef SYM_PREAMBLE_EN
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
`endif

        if (drain) begin
            sym_valid_d = 1'b0;
        end

        if (in_run && !en) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (bit_acc) begin
            sr_d = {sr_q[1:0], bit_in};
            if (cnt_q == 2'd3) begin
                i_d         = gray_level(sr_q[2:1]);
                q_d         = gray_level({sr_q[0], bit_in});
                sym_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end

`ifdef SYM_PREAMBLE_EN
        if (state_q == ST_PRE) begin
            if (drain) begin
                pre_cnt_d = pre_cnt_q + PCW'(1);
                if (pre_cnt_q == PCW'(PRE_LEN - 1)) begin
                    state_d = ST_RUN;
                end
            end
            if ((!sym_valid_q || sym_ready) && (pre_launched < (PCW + 1)'(PRE_LEN))) begin
                i_d         = pre_launched[0] ? gray_level(2'b00) : gray_level(2'b10);
                q_d         = pre_launched[0] ? gray_level(2'b00) : gray_level(2'b10);
                sym_valid_d = 1'b1;
            end
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            i_q         <= '0;
            q_q         <= '0;
            sym_valid_q <= 1'b0;
`ifdef SYM_PREAMBLE_EN
            state_q     <= ST_PRE;
            pre_cnt_q   <= '0;
`endif
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            q_q         <= q_d;
            sym_valid_q <= sym_valid_d;
`ifdef SYM_PREAMBLE_EN
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
`endif
        end
    end

    assign I_out     = i_q;
    assign Q_out     = q_q;
    assign sym_valid = sym_valid_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: accepted bits feed a nibble-level reference model whose
// expected symbols are queued; a negedge monitor pops and compares on every drained symbol.
module tb_qam_mapper;

    localparam int WIDTH   = 8;
    localparam int AMP     = 32;
    localparam int PRE_LEN = 8;

    logic             dclk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             sym_ready = 1'b0;
    logic             bit_ready;
    logic             sym_valid;
    logic [WIDTH-1:0] I_out;
    logic [WIDTH-1:0] Q_out;

    typedef struct {
        int i;
        int q;
    } sym_t;

    sym_t     exp_q[$];
    int       lut[4];
    logic [3:0] nib = '0;
    int       nbits = 0;
    int       errors = 0;
    int       checks = 0;
    int       stall_cycles = 0;
    logic     rand_ready = 1'b0;
    logic     forced_ready = 1'b1;
    logic     held_valid = 1'b0;
    int       held_i = 0;
    int       held_q = 0;

    qam_mapper #(.WIDTH(WIDTH), .AMP(AMP), .PRE_LEN(PRE_LEN)) dut (
        .dclk     (dclk),
        .rst      (rst),
        .en       (en),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .I_out    (I_out),
        .Q_out    (Q_out),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: group accepted bits into nibbles and look up each 2-bit half in the Gray table.
    task automatic model_bit(input logic b);
        sym_t s;
        nib = {nib[2:0], b};
        nbits++;
        if (nbits == 4) begin
            s.i = lut[nib[3:2]];
            s.q = lut[nib[1:0]];
            exp_q.push_back(s);
            nbits = 0;
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge dclk);
            if (bit_ready) begin
                model_bit(b);
                tick();
                bit_valid = 1'b0;
                return;
            end
            stall_cycles++;
            tick();
        end
        bit_valid = 1'b0;
        check("bit_accept_timeout", 0, 1);
    endtask

    task automatic wait_drained();
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0 && !sym_valid) return;
            tick();
        end
        check("drain_timeout_queue", exp_q.size(), 0);
    endtask

`ifdef SYM_PREAMBLE_EN
    task automatic do_preamble();
        sym_t s;
        for (int k = 0; k < PRE_LEN; k++) begin
            s.i = (k % 2 == 0) ? 3 * AMP : -3 * AMP;
            s.q = s.i;
            exp_q.push_back(s);
        end
        for (int n = 0; n < 100; n++) begin
            tick();
            if (exp_q.size() == 0) begin
                check("pre_bit_ready_after", int'(bit_ready), 1);
                return;
            end
            check("pre_bit_ready_low", int'(bit_ready), 0);
        end
        check("preamble_timeout", exp_q.size(), 0);
    endtask
`endif

    // sym_ready is updated 2 time units after each edge, after the main stimulus has settled.
    always @(posedge dclk) begin
        #2;
        sym_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    always @(negedge dclk) begin
        sym_t s;
        if (rst && sym_valid) begin
            if (held_valid) begin
                check("hold_I", int'($signed(I_out)), held_i);
                check("hold_Q", int'($signed(Q_out)), held_q);
            end
            if (sym_ready) begin
                held_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol: got I=%0d Q=%0d, required none (t=%0t)",
                             $signed(I_out), $signed(Q_out), $time);
                end else begin
                    s = exp_q.pop_front();
                    check("sym_I", int'($signed(I_out)), s.i);
                    check("sym_Q", int'($signed(Q_out)), s.q);
                end
            end else begin
                held_valid = 1'b1;
                held_i     = int'($signed(I_out));
                held_q     = int'($signed(Q_out));
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        lut[0] = -3 * AMP;
        lut[1] = -AMP;
        lut[2] = 3 * AMP;
        lut[3] = AMP;

        // Reset values (en is high, so bit_ready low comes from reset alone)
        #12;
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_I", int'($signed(I_out)), 0);
        check("rst_Q", int'($signed(Q_out)), 0);
        check("rst_bit_ready", int'(bit_ready), 0);
        @(negedge dclk);
        rst = 1'b1;
`ifdef SYM_PREAMBLE_EN
        do_preamble();
`endif
        tick();

        // 1: single symbol 1011 and its latency
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("t1_valid", int'(sym_valid), 1);
        check("t1_I", int'($signed(I_out)), 96);
        check("t1_Q", int'($signed(Q_out)), 32);
        tick();
        check("t1_valid_clear", int'(sym_valid), 0);

        // 2: all 16 nibbles back-to-back without a stall
        stall_cycles = 0;
        for (int v = 0; v < 16; v++) begin
            for (int k = 3; k >= 0; k--) send_bit(v[k]);
        end
        check("t2_no_stall", stall_cycles, 0);
        wait_drained();

        // 3: back-pressure stalls the 8th bit, then releases it with no loss
        forced_ready = 1'b0;
        tick();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge dclk);
            check("t3_stall_bit_ready", int'(bit_ready), 0);
            check("t3_held_I", int'($signed(I_out)), 96);
            check("t3_held_Q", int'($signed(Q_out)), -32);
            tick();
        end
        forced_ready = 1'b1;
        @(negedge dclk);
        check("t3_release_bit_ready", int'(bit_ready), 1);
        if (bit_ready) model_bit(1'b0);
        tick();
        bit_valid = 1'b0;
        check("t3_second_valid", int'(sym_valid), 1);
        check("t3_second_I", int'($signed(I_out)), -32);
        check("t3_second_Q", int'($signed(Q_out)), 96);
        wait_drained();

        // 4: en low discards a partial symbol
        send_bit(1'b1); send_bit(1'b1);
        en = 1'b0;
        tick();
        en    = 1'b1;
        nbits = 0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("t4_I", int'($signed(I_out)), -96);
        check("t4_Q", int'($signed(Q_out)), -32);
        wait_drained();

        // 5: asynchronous reset with a pending symbol and a partial one
        forced_ready = 1'b0;
        tick();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", int'(sym_valid), 0);
        check("t5_rst_I", int'($signed(I_out)), 0);
        check("t5_rst_Q", int'($signed(Q_out)), 0);
        check("t5_rst_bit_ready", int'(bit_ready), 0);
        exp_q.delete();
        nbits        = 0;
        forced_ready = 1'b1;
        @(negedge dclk);
        rst = 1'b1;
`ifdef SYM_PREAMBLE_EN
        do_preamble();
`endif
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t5_no_symbol", int'(sym_valid), 0);
        end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("t5_I", int'($signed(I_out)), -96);
        check("t5_Q", int'($signed(Q_out)), 96);
        wait_drained();

        // Random bits, random back-pressure, idle gaps and en pulses
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 19))
                0: begin
                    en = 1'b0;
                    tick();
                    en    = 1'b1;
                    nbits = 0;
                end
                1: tick();
                default: send_bit(1'($urandom_range(0, 1)));
            endcase
        end
        rand_ready   = 1'b0;
        forced_ready = 1'b1;
        tick();
        wait_drained();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
